// File: rtl/rca_config_sequencer_pkg.sv
// Shared state encoding and default sizing for the RCA configuration sequencer.
package rca_config_sequencer_pkg;

  localparam int DEF_NUM_CONFIGS = 4;
  localparam int DEF_CFG_WORDS   = 8;
  localparam int DEF_CFG_WORD_W  = 32;

  typedef enum logic [2:0] {
    CFG_IDLE,
    CFG_DRAIN,
    CFG_LOAD,
    CFG_SETTLE,
    CFG_DONE
  } rca_cfg_state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_inflight_tracker.sv
// Counts RCA operations between issue and writeback; saturates at both ends
// and flags illegal completes/issues. Zero/full flags are decoded from the count.
module rca_inflight_tracker
  import rca_config_sequencer_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic complete,
  output logic zero,
  output logic full
);

  localparam int CNT_W = clog2_min1(MAX_INFLIGHT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({issue, complete})
        2'b10:   if (!full) count <= count + 1'b1;
        2'b01:   if (!zero) count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign zero = (count == '0);
  assign full = (count == CNT_W'(MAX_INFLIGHT));

  assert property (@(posedge clk) disable iff (!rst) !(complete && !issue && zero))
    else $error("rca_complete with no RCA operation in flight");
  assert property (@(posedge clk) disable iff (!rst) !(issue && !complete && full))
    else $error("rca_issue with MAX_INFLIGHT operations already in flight");

endmodule

// File: rtl/rca_config_sequencer.sv
// Drains in-flight RCA ops, streams a stored configuration into the RCA config
// registers, settles, then re-enables issue. RCA_CFG_SKIP_RELOAD_EN skips reloading the active id.
module rca_config_sequencer
  import rca_config_sequencer_pkg::*;
#(
  parameter int NUM_CONFIGS   = DEF_NUM_CONFIGS,
  parameter int CFG_WORDS     = DEF_CFG_WORDS,
  parameter int CFG_WORD_W    = DEF_CFG_WORD_W,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_INFLIGHT  = 4,
  localparam int ID_W   = clog2_min1(NUM_CONFIGS),
  localparam int ADDR_W = clog2_min1(NUM_CONFIGS * CFG_WORDS),
  localparam int IDX_W  = clog2_min1(CFG_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_req_valid,
  input  logic [ID_W-1:0]       cfg_req_id,
  output logic                  cfg_req_ready,
  output logic                  cfg_done,
  input  logic                  rca_issue,
  input  logic                  rca_complete,
  output logic                  rca_issue_hold,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [CFG_WORD_W-1:0] mem_rd_data,
  output logic                  cfg_wr_en,
  output logic [IDX_W-1:0]      cfg_wr_idx,
  output logic [CFG_WORD_W-1:0] cfg_wr_data,
  output logic [ID_W-1:0]       active_cfg_id,
  output logic                  active_cfg_valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CFG_WORDS + 1);
  localparam int SET_W = clog2_min1(SETTLE_CYCLES);

  rca_cfg_state_t      state_q, state_d;
  logic [ID_W-1:0]     req_id_q, req_id_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [ID_W-1:0]     act_id_q, act_id_d;
  logic                act_vld_q, act_vld_d;
  logic                done_q, done_d;
  logic                skip_hit;
  logic                if_zero;
  logic                if_full;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ID_W-1:0] id,
                                                  input logic [IDX_W-1:0] word);
    return ADDR_W'(ADDR_W'(id) * ADDR_W'(CFG_WORDS) + ADDR_W'(word));
  endfunction

  rca_inflight_tracker #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_inflight (
    .clk      (clk),
    .rst      (rst),
    .issue    (rca_issue),
    .complete (rca_complete),
    .zero     (if_zero),
    .full     (if_full)
  );

`ifdef RCA_CFG_SKIP_RELOAD_EN
  assign skip_hit = act_vld_q && (cfg_req_id == act_id_q);
`else
  assign skip_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_id_d  = req_id_q;
    rd_cnt_d  = rd_cnt_q;
    settle_d  = settle_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    act_id_d  = act_id_q;
    act_vld_d = act_vld_q;
    done_d    = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_req_valid) begin
          req_id_d = cfg_req_id;
          if (skip_hit) begin
            state_d = CFG_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CFG_DRAIN;
          end
        end
      end
      CFG_DRAIN: begin
        // The old configuration stops being valid the moment it starts being overwritten.
        if (if_zero) begin
          state_d   = CFG_LOAD;
          act_vld_d = 1'b0;
          rd_en_d   = 1'b1;
          rd_addr_d = word_addr(req_id_q, '0);
          rd_cnt_d  = CNT_W'(1);
        end
      end
      CFG_LOAD: begin
        // Write side trails the read side by the one-cycle memory latency.
        wr_en_d  = rd_en_q;
        if (rd_en_q) wr_idx_d = IDX_W'(rd_cnt_q - 1'b1);
        if (rd_cnt_q < CNT_W'(CFG_WORDS)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = word_addr(req_id_q, IDX_W'(rd_cnt_q));
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end
        if (wr_en_q && (wr_idx_q == IDX_W'(CFG_WORDS - 1))) begin
          state_d  = CFG_SETTLE;
          wr_en_d  = 1'b0;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
        end
      end
      CFG_SETTLE: begin
        if (settle_q == '0) begin
          state_d   = CFG_DONE;
          done_d    = 1'b1;
          act_id_d  = req_id_q;
          act_vld_d = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      CFG_DONE: state_d = CFG_IDLE;
      default:  state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CFG_IDLE;
      req_id_q  <= '0;
      rd_cnt_q  <= '0;
      settle_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      act_id_q  <= '0;
      act_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_id_q  <= req_id_d;
      rd_cnt_q  <= rd_cnt_d;
      settle_q  <= settle_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      act_id_q  <= act_id_d;
      act_vld_q <= act_vld_d;
      done_q    <= done_d;
    end
  end

  assign cfg_req_ready    = (state_q == CFG_IDLE);
  assign busy             = (state_q != CFG_IDLE);
  assign rca_issue_hold   = busy | ~act_vld_q | if_full;
  assign cfg_done         = done_q;
  assign mem_rd_en        = rd_en_q;
  assign mem_rd_addr      = rd_addr_q;
  assign cfg_wr_en        = wr_en_q;
  assign cfg_wr_idx       = wr_idx_q;
  assign cfg_wr_data      = wr_en_q ? mem_rd_data : '0;
  assign active_cfg_id    = act_id_q;
  assign active_cfg_valid = act_vld_q;

endmodule

// File: tb/tb_rca_config_sequencer.sv
// Randomized and directed bench for rca_config_sequencer against a timeline model.
module tb_rca_config_sequencer;

  localparam int NUM_CONFIGS   = 4;
  localparam int CFG_WORDS     = 8;
  localparam int CFG_WORD_W    = 32;
  localparam int SETTLE_CYCLES = 2;
  localparam int MAX_INFLIGHT  = 4;
  localparam int ID_W          = 2;
  localparam int ADDR_W        = 5;
  localparam int IDX_W         = 3;
  localparam int NEVER         = 1 << 30;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  cfg_req_valid = 1'b0;
  logic [ID_W-1:0]       cfg_req_id = '0;
  logic                  cfg_req_ready;
  logic                  cfg_done;
  logic                  rca_issue = 1'b0;
  logic                  rca_complete = 1'b0;
  logic                  rca_issue_hold;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic [CFG_WORD_W-1:0] mem_rd_data = '0;
  logic                  cfg_wr_en;
  logic [IDX_W-1:0]      cfg_wr_idx;
  logic [CFG_WORD_W-1:0] cfg_wr_data;
  logic [ID_W-1:0]       active_cfg_id;
  logic                  active_cfg_valid;
  logic                  busy;

  always #5 clk = ~clk;

  rca_config_sequencer #(
    .NUM_CONFIGS  (NUM_CONFIGS),
    .CFG_WORDS    (CFG_WORDS),
    .CFG_WORD_W   (CFG_WORD_W),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_req_valid   (cfg_req_valid),
    .cfg_req_id      (cfg_req_id),
    .cfg_req_ready   (cfg_req_ready),
    .cfg_done        (cfg_done),
    .rca_issue       (rca_issue),
    .rca_complete    (rca_complete),
    .rca_issue_hold  (rca_issue_hold),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_idx      (cfg_wr_idx),
    .cfg_wr_data     (cfg_wr_data),
    .active_cfg_id   (active_cfg_id),
    .active_cfg_valid(active_cfg_valid),
    .busy            (busy)
  );

  logic [CFG_WORD_W-1:0] mem [NUM_CONFIGS*CFG_WORDS];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Timeline model: a request accepted at t_acc drains until the first cycle d
  // that starts with nothing in flight; everything else is an offset from d.
  bit m_idle = 1'b1;
  bit m_skip = 1'b0;
  int m_tacc = 0;
  int m_id   = 0;
  int m_d    = -1;
  int m_done = NEVER;
  int m_inf  = 0;
  bit m_act_vld = 1'b0;
  int m_act_id  = 0;
  bit prev_rd = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [ID_W-1:0] id,
                      input bit iss, input bit cmp);
    bit e_busy, e_rd, e_wr, e_done, e_hold;
    @(negedge clk);
    rst = r;
    if (!r) begin
      m_idle = 1'b1; m_inf = 0; m_act_vld = 1'b0; m_act_id = 0;
      v = 1'b0; iss = 1'b0; cmp = 1'b0;
    end
    if (iss && !cmp && m_inf == MAX_INFLIGHT) iss = 1'b0;
    if (cmp && !iss && m_inf == 0) cmp = 1'b0;
    mem_rd_data   = prev_rd ? mem[prev_addr] : $urandom();
    cfg_req_valid = v;
    cfg_req_id    = id;
    rca_issue     = iss;
    rca_complete  = cmp;
    #1;
    if (!m_idle && !m_skip && m_d < 0 && cyc >= m_tacc + 1 && m_inf == 0) begin
      m_d    = cyc;
      m_done = cyc + CFG_WORDS + SETTLE_CYCLES + 2;
    end
    e_busy = !m_idle;
    e_rd   = e_busy && !m_skip && m_d >= 0 && cyc >= m_d + 1 && cyc <= m_d + CFG_WORDS;
    e_wr   = e_busy && !m_skip && m_d >= 0 && cyc >= m_d + 2 && cyc <= m_d + CFG_WORDS + 1;
    e_done = e_busy && cyc == m_done;
    e_hold = e_busy || !m_act_vld || m_inf == MAX_INFLIGHT;
    chk("cfg_req_ready", cfg_req_ready, !e_busy);
    chk("busy", busy, e_busy);
    chk("cfg_done", cfg_done, e_done);
    chk("rca_issue_hold", rca_issue_hold, e_hold);
    chk("mem_rd_en", mem_rd_en, e_rd);
    chk("cfg_wr_en", cfg_wr_en, e_wr);
    chk("active_cfg_valid", active_cfg_valid, m_act_vld);
    chk("active_cfg_id", active_cfg_id, m_act_id);
    if (e_rd) chk("mem_rd_addr", mem_rd_addr, m_id * CFG_WORDS + (cyc - m_d - 1));
    if (e_wr) begin
      chk("cfg_wr_idx", cfg_wr_idx, cyc - m_d - 2);
      chk("cfg_wr_data", cfg_wr_data, mem[m_id * CFG_WORDS + (cyc - m_d - 2)]);
    end
    if (!r) begin
      chk("reset_rd_addr", mem_rd_addr, 0);
      chk("reset_wr_idx", cfg_wr_idx, 0);
      chk("reset_wr_data", cfg_wr_data, 0);
    end
    prev_rd   = r && mem_rd_en;
    prev_addr = mem_rd_addr;
    @(posedge clk);
    if (r) begin
      if (m_idle) begin
        if (v) begin
          m_idle = 1'b0; m_tacc = cyc; m_id = int'(id); m_d = -1; m_done = NEVER;
          m_skip = 1'b0;
`ifdef RCA_CFG_SKIP_RELOAD_EN
          if (m_act_vld && int'(id) == m_act_id) begin
            m_skip = 1'b1;
            m_done = cyc + 1;
          end
`endif
        end
      end else begin
        if (!m_skip && cyc == m_d) m_act_vld = 1'b0;
        if (cyc == m_done - 1) begin
          m_act_vld = 1'b1;
          m_act_id  = m_id;
        end
        if (cyc == m_done) m_idle = 1'b1;
      end
      if (iss && !cmp) m_inf++;
      else if (cmp && !iss) m_inf--;
    end
    cyc++;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NUM_CONFIGS * CFG_WORDS; i++) mem[i] = $urandom();

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Plain load of id 2 with nothing in flight.
    step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    idle_run(16);

    // Three ops in flight, request id 1, completions trickle in during drain.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++)
      step(1'b1, k == 0, 2'd1, 1'b0, (k == 3) || (k == 5) || (k == 7));

    // Simultaneous issue/complete, then fill to MAX_INFLIGHT and drain back.
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle_run(2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Reset lands while word 4 is being read.
    step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    idle_run(5);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle_run(2);

    // Load id 3 twice back to back.
    step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    idle_run(16);
    step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    idle_run(16);

    // Request held valid with a wandering id.
    for (int k = 0; k < 30; k++) step(1'b1, 1'b1, ID_W'(k % NUM_CONFIGS), 1'b0, 1'b0);
    idle_run(16);

    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 399) != 0, $urandom_range(0, 3) == 0,
           ID_W'($urandom_range(0, NUM_CONFIGS - 1)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
    idle_run(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
